// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and port indices.
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arbState_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin selector: a lone request wins, and on a conflict the
// port that was not granted last wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic       anyGrant,
  output logic       grantIdx
);

  always_comb begin
    anyGrant = |req;
    grantIdx = PORT_CPU;
    unique case (req)
      2'b01:   grantIdx = PORT_CPU;
      2'b10:   grantIdx = PORT_IO;
      2'b11:   grantIdx = ~lastGrant;
      default: grantIdx = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and an I/O port onto one single-cycle memory; the grant
// is registered, and read data is captured at the end of the grant cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  r0_rvalid,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r0_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arbState_e state, nextState;
  logic      grantPort;
  logic      lastGrant;
  logic      arbValid;
  logic      arbIdx;
  logic      active;
  logic [1:0] gntRaw;
  logic [1:0] eligible;
  logic [1:0] rvalidQ;
  logic [1:0][DATA_WIDTH-1:0] rdataQ;
  logic [1:0][ADDR_WIDTH-1:0] addrs;
  logic [1:0][DATA_WIDTH-1:0] wdatas;
  logic [1:0] wes;

  assign addrs  = {r1_addr, r0_addr};
  assign wdatas = {r1_wdata, r0_wdata};
  assign wes    = {r1_we, r0_we};

  // A port's request in its own grant cycle is already being served, so it
  // only counts again once it is seen high in the following cycle.
  assign gntRaw[PORT_CPU] = (state == ACCESS) && (grantPort == PORT_CPU);
  assign gntRaw[PORT_IO]  = (state == ACCESS) && (grantPort == PORT_IO);
  assign eligible = {r1_req & ~gntRaw[PORT_IO], r0_req & ~gntRaw[PORT_CPU]};

  rr_arbiter2 uArb (
    .req       (eligible),
    .lastGrant (lastGrant),
    .anyGrant  (arbValid),
    .grantIdx  (arbIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grantPort <= PORT_CPU;
      lastGrant <= PORT_IO;
    end else begin
      state <= nextState;
      if (arbValid) begin
        grantPort <= arbIdx;
        lastGrant <= arbIdx;
      end
    end
  end

  // Reset gates everything combinationally so an in-flight access is dropped
  // in the very cycle reset rises.
  always_comb begin
    nextState = arbValid ? ACCESS : IDLE;
    active    = (state == ACCESS) && !reset;
    r0_gnt    = active && (grantPort == PORT_CPU);
    r1_gnt    = active && (grantPort == PORT_IO);
    r0_stall  = r0_req && !r0_gnt;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (active) begin
      mem_we    = wes[grantPort];
      mem_re    = ~wes[grantPort];
      mem_addr  = addrs[grantPort];
      mem_wdata = wdatas[grantPort];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalidQ <= '0;
      rdataQ  <= '0;
    end else begin
      rvalidQ <= '0;
      if (mem_re) begin
        rvalidQ[grantPort] <= 1'b1;
        rdataQ[grantPort]  <= mem_rdata;
      end
    end
  end

  assign r0_rvalid = !reset && rvalidQ[PORT_CPU];
  assign r1_rvalid = !reset && rvalidQ[PORT_IO];
  assign r0_rdata  = reset ? '0 : rdataQ[PORT_CPU];
  assign r1_rdata  = reset ? '0 : rdataQ[PORT_IO];

endmodule
